// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the audio sample cache write arbiter.
// Optional grant statistics are enabled with CACHE_ARB_STATS_EN.
package cache_arb_pkg;

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ARB   = ST_ARB,
    CLEAR = ST_CLEAR,
    DONE  = ST_DONE
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_DATA_W  = 16;
  localparam int STAT_W      = 16;

endpackage

// File: rtl/cache_write_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate, find lowest, rotate back.
// Search starts at ptr and wraps upward.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  int             sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N];
    any = |req;
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = PW'(j);
    end
    sum = int'(off) + int'(ptr);
    if (sum >= N) sum = sum - N;
    idx = PW'(sum);
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/cache_write_arbiter.sv
// Round-robin write-port arbiter with clear sequencer for the sample cache.
// Define CACHE_ARB_STATS_EN to add per-requester saturating grant counters.
module cache_write_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      clear_req,
  output logic                      busy,
  output logic                      clear_done,
  output logic                      wr,
  output logic [ADDR_W-1:0]         Addr_W,
  output logic [DATA_W-1:0]         Data_W
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_cnt
`endif
);

  localparam int PW    = $clog2(NUM_REQ);
  localparam int CW    = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  state_e              state;
  state_e              nxt;
  logic [PW-1:0]       ptr;
  logic [CW-1:0]       cnt;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [PW-1:0]       pick_idx;
  logic                pick_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                take;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_addr = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    sel_data = req_data[int'(pick_idx)*DATA_W +: DATA_W];
  end

  always_comb begin
    nxt        = state;
    gnt        = '0;
    busy       = 1'b0;
    clear_done = 1'b0;
    take       = 1'b0;
    unique case (state)
      ARB: begin
        if (clear_req) begin
          nxt = CLEAR;
        end else if (pick_any) begin
          gnt  = pick_gnt;
          take = 1'b1;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (cnt == CW'(DEPTH - 1)) nxt = DONE;
      end
      DONE: begin
        clear_done = 1'b1;
        nxt        = ARB;
      end
      default: nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ARB;
      ptr    <= '0;
      cnt    <= '0;
      wr     <= 1'b0;
      Addr_W <= '0;
      Data_W <= '0;
    end else begin
      state <= nxt;
      wr    <= 1'b0;
      if (state == ARB && clear_req) begin
        cnt <= '0;
      end else if (take) begin
        wr     <= 1'b1;
        Addr_W <= sel_addr;
        Data_W <= sel_data;
        if (int'(pick_idx) == NUM_REQ - 1) ptr <= '0;
        else ptr <= pick_idx + 1'b1;
      end else if (state == CLEAR) begin
        wr     <= 1'b1;
        Addr_W <= cnt[ADDR_W-1:0];
        Data_W <= '0;
        cnt    <= cnt + 1'b1;
      end
    end
  end

`ifdef CACHE_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (state == ARB && clear_req) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (take && stat_q[pick_idx] != '1) begin
      stat_q[pick_idx] <= stat_q[pick_idx] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_cnt[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_cache_write_arbiter.sv
// Directed self-checking bench for cache_write_arbiter.
// Stats checks run only when CACHE_ARB_STATS_EN is defined.
module tb_cache_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      clear_req;
  logic                      busy;
  logic                      clear_done;
  logic                      wr;
  logic [ADDR_W-1:0]         Addr_W;
  logic [DATA_W-1:0]         Data_W;
`ifdef CACHE_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     stat_cnt;
`endif

  cache_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gnt        (gnt),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .wr         (wr),
    .Addr_W     (Addr_W),
    .Data_W     (Data_W)
`ifdef CACHE_ARB_STATS_EN
    ,
    .stat_cnt   (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [DATA_W-1:0] sb_mem  [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  always @(posedge clk) begin
    if (wr) sb_mem[Addr_W] <= Data_W;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req[i] = 1'b1;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    req       = '0;
    req_addr  = '0;
    req_data  = '0;
    clear_req = 1'b0;
    repeat (2) tick;
    check("rst_wr",    wr, 0);
    check("rst_addr",  Addr_W, 0);
    check("rst_data",  Data_W, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  clear_done, 0);
    check("rst_gnt",   gnt, 0);
    @(negedge clk) rst = 1'b1;
    tick;

    // single request from requester 2
    set_req(2, 3'd5, 16'hA5A5);
    #1 check("t1_gnt", gnt, 4'b0100);
    tick;
    req = '0;
    check("t1_wr",   wr, 1);
    check("t1_addr", Addr_W, 5);
    check("t1_data", Data_W, 16'hA5A5);
    tick;
    check("t1_wr_lo",  wr, 0);
    check("t1_hold_a", Addr_W, 5);
    check("t1_hold_d", Data_W, 16'hA5A5);

    // bring pointer back to 0
    set_req(3, 3'd7, 16'h7777);
    #1 check("t1b_gnt", gnt, 4'b1000);
    tick;
    req = '0;
    check("t1b_addr", Addr_W, 7);

    // full load round robin
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'(i), 16'h1000 + 16'(i));
    for (int k = 0; k < 8; k++) begin
      #1 check("t2_gnt", gnt, 4'b0001 << (k % 4));
      if (k > 0) begin
        check("t2_wr",   wr, 1);
        check("t2_addr", Addr_W, (k - 1) % 4);
        check("t2_data", Data_W, 16'h1000 + (k - 1) % 4);
      end
      tick;
    end
    req = '0;
    check("t2_wr_last",   wr, 1);
    check("t2_addr_last", Addr_W, 3);
    tick;
    check("t2_wr_off", wr, 0);

    // clear wins over a simultaneous request
    set_req(1, 3'd6, 16'hBEEF);
    clear_req = 1'b1;
    #1 check("t3_gnt0", gnt, 0);
    tick;
    clear_req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      #1;
      check("t3_busy", busy, k <= 8);
      check("t3_wr",   wr, k >= 2);
      if (k >= 2) begin
        check("t3_addr", Addr_W, k - 2);
        check("t3_data", Data_W, 0);
      end
      check("t3_done", clear_done, k == 9);
      check("t3_gnt",  gnt, 0);
      clear_req = (k == 3);
      tick;
    end
    clear_req = 1'b0;
    check("t3_gnt1", gnt, 4'b0010);
    check("t3_done_off", clear_done, 0);
    check("t3_busy_off", busy, 0);
    tick;
    req = '0;
    check("t3_wr",   wr, 1);
    check("t3_addr", Addr_W, 6);
    check("t3_data", Data_W, 16'hBEEF);

    // reset in the middle of a sweep
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    repeat (3) tick;
    check("t4_pre_wr",   wr, 1);
    check("t4_pre_addr", Addr_W, 2);
    rst = 1'b0;
    #1;
    check("t4_wr",   wr, 0);
    check("t4_busy", busy, 0);
    check("t4_addr", Addr_W, 0);
    repeat (3) tick;
    @(negedge clk) rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (clear_done || busy) seen = 1'b1;
    end
    check("t4_no_done", seen, 0);
    set_req(0, 3'd4, 16'h1234);
    #1 check("t4_gnt", gnt, 4'b0001);
    tick;
    req = '0;
    check("t4_wr",   wr, 1);
    check("t4_wdat", Data_W, 16'h1234);

    // scoreboard: full clear then mixed writes, ptr is 1 here
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (clear_done) seen = 1'b1;
      else tick;
    end
    check("sb_clear_done", seen, 1);
    tick;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    set_req(2, 3'd1, 16'h2222);
    set_req(0, 3'd3, 16'h0303);
    #1 check("sb_gnt_a", gnt, 4'b0100);
    tick;
    req[2] = 1'b0;
    #1 check("sb_gnt_b", gnt, 4'b0001);
    tick;
    req = '0;
    set_req(3, 3'd1, 16'h3131);
    #1 check("sb_gnt_c", gnt, 4'b1000);
    tick;
    req = '0;
    set_req(1, 3'd6, 16'h6666);
    #1 check("sb_gnt_d", gnt, 4'b0010);
    tick;
    req = '0;
    repeat (3) tick;
    exp_mem[1] = 16'h3131;
    exp_mem[3] = 16'h0303;
    exp_mem[6] = 16'h6666;
    for (int i = 0; i < DEPTH; i++) check("sb_mem", sb_mem[i], exp_mem[i]);

`ifdef CACHE_ARB_STATS_EN
    set_req(3, 3'd0, 16'h0);
    repeat (70000) tick;
    req = '0;
    tick;
    check("st_sat", stat_cnt[3*16 +: 16], 16'hFFFF);
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) check("st_clr", stat_cnt[i*16 +: 16], 0);
    repeat (12) tick;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
